// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the unified 16-bit data memory between the fetch port (I) and
//   the memory-stage port (D). One access is in flight at a time. The FSM
//   walks IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP -> IDLE. Read data
//   is returned together with a one-cycle done pulse. D normally has
//   priority. An aging counter lets I win after MAX_WAIT consecutive losses.
//
// Parameters
//   MEM_LAT   cycles from mem_en to valid mem_rdata (>= 1)
//   MAX_WAIT  contentions I may lose in a row before it wins (0 = D always wins)
//
// Ports
//   clk, rst                     clock (rising edge), async active-high reset
//   i_req/i_addr                 fetch read request (level) and address
//   i_done/i_rdata               fetch completion pulse and held read data
//   d_req/d_wr/d_addr/d_wdata    data request (level), write flag, address, wdata
//   d_done/d_rdata               data completion pulse and held read data
//   mem_en/mem_wr/mem_addr/mem_wdata   memory command, registered, one-cycle en
//   mem_rdata                    memory read data, valid MEM_LAT cycles after en
//   busy                         high in any state other than IDLE
//
// Optional feature (macro ARB_STATS_EN)
//   Adds the saturating 16-bit counters i_grant_cnt, d_grant_cnt and
//   conflict_cnt. The counters and their ports exist only when the macro is
//   defined.
module mem_arbiter #(
   parameter int MEM_LAT  = 2,
   parameter int MAX_WAIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [15:0] i_addr,
   output logic        i_done,
   output logic [15:0] i_rdata,
   input  logic        d_req,
   input  logic        d_wr,
   input  logic [15:0] d_addr,
   input  logic [15:0] d_wdata,
   output logic        d_done,
   output logic [15:0] d_rdata,
   output logic        mem_en,
   output logic        mem_wr,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   output logic        busy
`ifdef ARB_STATS_EN
   ,
   output logic [15:0] i_grant_cnt,
   output logic [15:0] d_grant_cnt,
   output logic [15:0] conflict_cnt
`endif
);

   localparam int AGE_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam int CNT_W = (MEM_LAT <= 1) ? 1 : $clog2(MEM_LAT);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(MAX_WAIT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam bit               AGING_EN = (MAX_WAIT != 0);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

   state_t           state, state_nxt;
   logic             owner_i;   // 1 = current access belongs to the fetch port
   logic             req_wr;    // current access is a write (suppresses rdata capture)
   logic [AGE_W-1:0] age;
   logic [CNT_W-1:0] wait_cnt;
   logic             any_req;
   logic             grant_i;

   assign any_req = i_req | d_req;
   // I wins if it is alone, or if it has lost MAX_WAIT contentions in a row.
   assign grant_i = i_req & (~d_req | (AGING_EN && (age == AGE_MAX)));

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (any_req) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (wait_cnt == '0) state_nxt = ST_RESP;
         ST_RESP:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decoded from state. Async reset forces them low immediately.
   always_comb begin
      busy   = (state != ST_IDLE);
      i_done = (state == ST_RESP) &  owner_i;
      d_done = (state == ST_RESP) & ~owner_i;
   end

   // Request register, memory command, latency counter, aging, read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_i   <= 1'b0;
         req_wr    <= 1'b0;
         age       <= '0;
         wait_cnt  <= '0;
         mem_en    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         // mem_en/mem_wr are high only for the single ISSUE cycle.
         mem_en <= 1'b0;
         mem_wr <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  owner_i   <= grant_i;
                  req_wr    <= ~grant_i & d_wr;
                  mem_en    <= 1'b1;
                  mem_wr    <= ~grant_i & d_wr;
                  mem_addr  <= grant_i ? i_addr : d_addr;
                  mem_wdata <= grant_i ? 16'h0000 : d_wdata;
                  if (grant_i)
                     age <= '0;
                  else if (i_req && (age != AGE_MAX))
                     age <= age + AGE_W'(1);
               end
            end
            ST_ISSUE: wait_cnt <= CNT_LOAD;
            ST_WAIT: begin
               if (wait_cnt == '0) begin
                  if (!req_wr) begin
                     if (owner_i) i_rdata <= mem_rdata;
                     else         d_rdata <= mem_rdata;
                  end
               end else begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ARB_STATS_EN
   // Grant and conflict statistics, saturating at 0xFFFF
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_grant_cnt  <= '0;
         d_grant_cnt  <= '0;
         conflict_cnt <= '0;
      end else if (state == ST_IDLE) begin
         if (any_req && grant_i && (i_grant_cnt != 16'hFFFF))
            i_grant_cnt <= i_grant_cnt + 16'd1;
         if (any_req && !grant_i && (d_grant_cnt != 16'hFFFF))
            d_grant_cnt <= d_grant_cnt + 16'd1;
         if (i_req && d_req && (conflict_cnt != 16'hFFFF))
            conflict_cnt <= conflict_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter (MEM_LAT=2). The main instance uses
//   MAX_WAIT=3. A second instance uses MAX_WAIT=0 to check that D always wins.
//   A small memory model returns data exactly MEM_LAT cycles after mem_en and
//   returns 16'hDEAD at every other time.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_done, d_done, mem_en, mem_wr, busy;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

   logic        i_req2 = 1'b0, d_req2 = 1'b0;
   logic        i_done2, d_done2, mem_en2, mem_wr2, busy2;
   logic [15:0] i_rdata2, d_rdata2, mem_addr2, mem_wdata2;

`ifdef ARB_STATS_EN
   logic [15:0] i_grant_cnt, d_grant_cnt, conflict_cnt;
   logic [15:0] i_grant_cnt2, d_grant_cnt2, conflict_cnt2;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.MEM_LAT(2), .MAX_WAIT(3)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
`ifdef ARB_STATS_EN
      , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
      .conflict_cnt(conflict_cnt)
`endif
   );

   mem_arbiter #(.MEM_LAT(2), .MAX_WAIT(0)) dut0 (
      .clk(clk), .rst(rst),
      .i_req(i_req2), .i_addr(16'h0000), .i_done(i_done2), .i_rdata(i_rdata2),
      .d_req(d_req2), .d_wr(1'b0), .d_addr(16'h0000), .d_wdata(16'h0000),
      .d_done(d_done2), .d_rdata(d_rdata2),
      .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2),
      .mem_wdata(mem_wdata2), .mem_rdata(16'h0000), .busy(busy2)
`ifdef ARB_STATS_EN
      , .i_grant_cnt(i_grant_cnt2), .d_grant_cnt(d_grant_cnt2),
      .conflict_cnt(conflict_cnt2)
`endif
   );

   // Memory model: data is valid only in the cycle MEM_LAT=2 cycles after mem_en.
   logic        m_en1 = 1'b0, m_en2 = 1'b0;
   logic [15:0] m_a1 = '0, m_a2 = '0;

   function automatic logic [15:0] mem_val(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
   endfunction

   always @(posedge clk) begin
      m_en1 <= mem_en;
      m_a1  <= mem_addr;
      m_en2 <= m_en1;
      m_a2  <= m_a1;
   end
   assign mem_rdata = m_en2 ? mem_val(m_a2) : 16'hDEAD;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h required %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      i_req = 1'b0;
      d_req = 1'b0;
      d_wr  = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // Both ports request in c0. D (read) is served first, then I.
   task automatic run_contention();
      i_req = 1'b1; i_addr = 16'h0030;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
      step();  // c1
      chk("s3_mem_en_d", mem_en, 1);
      chk("s3_mem_addr_d", mem_addr, 16'h0020);
      step(); step(); step();  // c4
      chk("s3_d_done", d_done, 1);
      chk("s3_i_done_c4", i_done, 0);
      chk("s3_d_rdata", d_rdata, 16'hA585);
      step();  // c5
      d_req = 1'b0;
      step();  // c6
      chk("s3_mem_en_i", mem_en, 1);
      chk("s3_mem_addr_i", mem_addr, 16'h0030);
      step(); step(); step();  // c9
      chk("s3_i_done", i_done, 1);
      chk("s3_d_done_c9", d_done, 0);
      chk("s3_i_rdata", i_rdata, 16'hA595);
      i_req = 1'b0;
      step();
      chk("s3_idle", busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] seq;
      int ndone, nd2, ni2;

      // Reset state
      rst = 1'b1;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_i_done", i_done, 0);
      chk("rst_d_done", d_done, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      do_reset();

      // 1: I read of 0x0010
      i_req = 1'b1; i_addr = 16'h0010;
      chk("s1_busy_c0", busy, 0);
      chk("s1_mem_en_c0", mem_en, 0);
      step();  // c1
      chk("s1_mem_en", mem_en, 1);
      chk("s1_mem_addr", mem_addr, 16'h0010);
      chk("s1_mem_wr", mem_wr, 0);
      chk("s1_busy_c1", busy, 1);
      step();  // c2
      chk("s1_mem_en_c2", mem_en, 0);
      chk("s1_busy_c2", busy, 1);
      step();  // c3
      chk("s1_i_done_c3", i_done, 0);
      step();  // c4
      chk("s1_i_done", i_done, 1);
      chk("s1_d_done", d_done, 0);
      chk("s1_i_rdata", i_rdata, 16'hBEEF);
      chk("s1_busy_c4", busy, 1);
      i_req = 1'b0;
      step();  // c5
      chk("s1_i_done_c5", i_done, 0);
      chk("s1_busy_c5", busy, 0);

      // 2: D write of 0x1234 to 0x0100
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'h1234;
      step();  // c1
      chk("s2_mem_en", mem_en, 1);
      chk("s2_mem_wr", mem_wr, 1);
      chk("s2_mem_addr", mem_addr, 16'h0100);
      chk("s2_mem_wdata", mem_wdata, 16'h1234);
      step();  // c2
      chk("s2_mem_wr_c2", mem_wr, 0);
      step(); step();  // c4
      chk("s2_d_done", d_done, 1);
      chk("s2_i_done", i_done, 0);
      chk("s2_d_rdata", d_rdata, 16'h0000);
      chk("s2_i_rdata", i_rdata, 16'hBEEF);
      d_req = 1'b0; d_wr = 1'b0;
      step();
      chk("s2_d_done_c5", d_done, 0);

      // 3: contention
      run_contention();

      // 5: reset while in WAIT. The held request restarts after release.
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0040;
      step(); step();  // c2, WAIT
      chk("s5_busy_pre", busy, 1);
      rst = 1'b1;
      #1;
      chk("s5_busy_rst", busy, 0);
      chk("s5_mem_en_rst", mem_en, 0);
      chk("s5_d_done_rst", d_done, 0);
      chk("s5_d_rdata_rst", d_rdata, 0);
      step();  // c3, reset still high
      chk("s5_busy_c3", busy, 0);
      chk("s5_d_done_c3", d_done, 0);
      rst = 1'b0;
      step();  // first edge after release sampled d_req
      chk("s5_mem_en_restart", mem_en, 1);
      chk("s5_mem_addr_restart", mem_addr, 16'h0040);
      step();
      chk("s5_d_done_r1", d_done, 0);
      step();
      chk("s5_d_done_r2", d_done, 0);
      step();
      chk("s5_d_done", d_done, 1);
      chk("s5_d_rdata", d_rdata, 16'hA5E5);
      d_req = 1'b0;
      step();

      // 4: aging with both requests held high; the MAX_WAIT=0 instance runs alongside
      do_reset();
      i_req = 1'b1; i_addr = 16'h0050;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0060;
      i_req2 = 1'b1; d_req2 = 1'b1;
      seq = '0; ndone = 0; nd2 = 0; ni2 = 0;
      for (int c = 0; c < 80 && ndone < 8; c++) begin
         step();
         if (i_done && d_done) chk("s4_both_done", {i_done, d_done}, 2'b10);
         if (i_done2) ni2++;
         if (d_done2) nd2++;
         if (i_done || d_done) begin
            seq[ndone] = i_done;
            ndone++;
         end
      end
      chk("s4_done_count", ndone, 8);
      chk("s4_grant_order", seq, 8'b1000_1000);
      chk("s4_w0_i_done_count", ni2, 0);
      chk("s4_w0_d_done_count", nd2, 8);
      i_req = 1'b0; d_req = 1'b0; i_req2 = 1'b0; d_req2 = 1'b0;
      step(); step();

`ifdef ARB_STATS_EN
      // 6: statistics over two contention runs
      do_reset();
      chk("s6_i_cnt_rst", i_grant_cnt, 0);
      chk("s6_conf_rst", conflict_cnt, 0);
      run_contention();
      run_contention();
      chk("s6_i_grant_cnt", i_grant_cnt, 2);
      chk("s6_d_grant_cnt", d_grant_cnt, 2);
      chk("s6_conflict_cnt", conflict_cnt, 2);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
